// File: rtl/yuv_rgb_pkg.sv
// Shared types, BT.601 full-range Q8 coefficients and the clamp helper for the
// YUV 4:2:2 -> RGB888 decode path.
package yuv_rgb_pkg;

  localparam int unsigned PIX_W = 8;   // unsigned pixel component width
  localparam int unsigned MUL_W = 18;  // signed chroma product intermediate
  localparam int unsigned T_W   = 10;  // signed chroma term after >>> 8
  localparam int unsigned SUM_W = 11;  // signed Y + term before clamping
  localparam int unsigned FRAC  = 8;   // Q8 fraction bits

  localparam logic signed [MUL_W-1:0] CR_V = 18'sd359;
  localparam logic signed [MUL_W-1:0] CG_U = 18'sd88;
  localparam logic signed [MUL_W-1:0] CG_V = 18'sd183;
  localparam logic signed [MUL_W-1:0] CB_U = 18'sd454;
  localparam logic signed [MUL_W-1:0] RND  = 18'sd128;

  typedef struct packed {
    logic [PIX_W-1:0] y0;
    logic [PIX_W-1:0] y1;
    logic [PIX_W-1:0] u;
    logic [PIX_W-1:0] v;
  } yuv422_pair_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb888_t;

  // Saturate a signed 11-bit sum into 0..255.
  function automatic logic [PIX_W-1:0] clamp8(input logic signed [SUM_W-1:0] x);
    logic [PIX_W-1:0] res;
    if (x[SUM_W-1])
      res = '0;
    else if (x > 11'sd255)
      res = '1;
    else
      res = PIX_W'(x);
    return res;
  endfunction

endpackage

// File: rtl/yuv_pixel_recon.sv
// Combinational reconstruction of one RGB888 pixel from its luma and the
// pair's shared chroma terms.
//   y             : unsigned luma
//   t_r/t_g/t_b   : signed chroma terms (R = Y+tR, G = Y-tG, B = Y+tB)
//   rgb_c         : clamped RGB pixel
import yuv_rgb_pkg::*;

module yuv_pixel_recon (
  input  logic        [PIX_W-1:0] y,
  input  logic signed [T_W-1:0]   t_r,
  input  logic signed [T_W-1:0]   t_g,
  input  logic signed [T_W-1:0]   t_b,
  output rgb888_t                 rgb_c
);

  logic signed [SUM_W-1:0] y_sx;
  logic signed [SUM_W-1:0] sum_r;
  logic signed [SUM_W-1:0] sum_g;
  logic signed [SUM_W-1:0] sum_b;

  assign y_sx  = $signed({3'b000, y});
  assign sum_r = y_sx + SUM_W'(t_r);
  assign sum_g = y_sx - SUM_W'(t_g);
  assign sum_b = y_sx + SUM_W'(t_b);

  assign rgb_c.r = clamp8(sum_r);
  assign rgb_c.g = clamp8(sum_g);
  assign rgb_c.b = clamp8(sum_b);

endmodule

// File: rtl/yuv422_to_rgb888.sv
// Streaming YUV 4:2:2 pair -> two RGB888 pixels, two-stage valid/ready pipe.
//   clk, rst                 : clock, async active-high reset
//   i_valid/i_ready          : input pair handshake (i_ready is combinational)
//   i_y0, i_y1, i_u, i_v     : luma pair and shared chroma
//   o_valid/o_ready          : output pixel handshake
//   o_r, o_g, o_b            : registered RGB pixel
import yuv_rgb_pkg::*;

module yuv422_to_rgb888 (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [PIX_W-1:0] i_y0,
  input  logic [PIX_W-1:0] i_y1,
  input  logic [PIX_W-1:0] i_u,
  input  logic [PIX_W-1:0] i_v,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [PIX_W-1:0] o_r,
  output logic [PIX_W-1:0] o_g,
  output logic [PIX_W-1:0] o_b
);

  yuv422_pair_t in_pair;
  assign in_pair = '{y0: i_y0, y1: i_y1, u: i_u, v: i_v};

  // Chroma terms from the incoming pair, captured into S1 on acceptance.
  logic signed [8:0]       du;
  logic signed [8:0]       dv;
  logic signed [MUL_W-1:0] acc_r;
  logic signed [MUL_W-1:0] acc_g;
  logic signed [MUL_W-1:0] acc_b;
  logic signed [T_W-1:0]   t_r_c;
  logic signed [T_W-1:0]   t_g_c;
  logic signed [T_W-1:0]   t_b_c;

  assign du    = $signed({1'b0, in_pair.u}) - 9'sd128;
  assign dv    = $signed({1'b0, in_pair.v}) - 9'sd128;
  assign acc_r = CR_V * MUL_W'(dv) + RND;
  assign acc_g = CG_U * MUL_W'(du) + CG_V * MUL_W'(dv) + RND;
  assign acc_b = CB_U * MUL_W'(du) + RND;
  assign t_r_c = T_W'(acc_r >>> FRAC);
  assign t_g_c = T_W'(acc_g >>> FRAC);
  assign t_b_c = T_W'(acc_b >>> FRAC);

  // S1: luma pair plus chroma terms.
  logic                  s1_valid, s1_valid_nxt;
  logic [PIX_W-1:0]      s1_y0, s1_y0_nxt;
  logic [PIX_W-1:0]      s1_y1, s1_y1_nxt;
  logic signed [T_W-1:0] s1_tr, s1_tr_nxt;
  logic signed [T_W-1:0] s1_tg, s1_tg_nxt;
  logic signed [T_W-1:0] s1_tb, s1_tb_nxt;

  // S2: the visible pixel is held in out_q; pix1_q waits for phase 1.
  logic    s2_valid, s2_valid_nxt;
  logic    phase, phase_nxt;
  rgb888_t out_q, out_nxt;
  rgb888_t pix1_q, pix1_nxt;

  rgb888_t rec0_c;
  rgb888_t rec1_c;

  yuv_pixel_recon u_recon0 (
    .y(s1_y0), .t_r(s1_tr), .t_g(s1_tg), .t_b(s1_tb), .rgb_c(rec0_c)
  );

  yuv_pixel_recon u_recon1 (
    .y(s1_y1), .t_r(s1_tr), .t_g(s1_tg), .t_b(s1_tb), .rgb_c(rec1_c)
  );

  // S2 can take a new pair when empty or when its last pixel leaves this edge.
  logic move_c;
  logic in_hs_c;
  logic out_hs_c;

  assign move_c   = s1_valid && (!s2_valid || (phase && o_ready));
  assign i_ready  = !s1_valid || move_c;
  assign in_hs_c  = i_valid && i_ready;
  assign out_hs_c = s2_valid && o_ready;

  // Next-state for both stages.
  always_comb begin
    s1_valid_nxt = s1_valid;
    s1_y0_nxt    = s1_y0;
    s1_y1_nxt    = s1_y1;
    s1_tr_nxt    = s1_tr;
    s1_tg_nxt    = s1_tg;
    s1_tb_nxt    = s1_tb;
    s2_valid_nxt = s2_valid;
    phase_nxt    = phase;
    out_nxt      = out_q;
    pix1_nxt     = pix1_q;

    if (in_hs_c) begin
      s1_valid_nxt = 1'b1;
      s1_y0_nxt    = in_pair.y0;
      s1_y1_nxt    = in_pair.y1;
      s1_tr_nxt    = t_r_c;
      s1_tg_nxt    = t_g_c;
      s1_tb_nxt    = t_b_c;
    end else if (move_c) begin
      s1_valid_nxt = 1'b0;
    end

    if (move_c) begin
      s2_valid_nxt = 1'b1;
      phase_nxt    = 1'b0;
      out_nxt      = rec0_c;
      pix1_nxt     = rec1_c;
    end else if (out_hs_c) begin
      if (!phase) begin
        phase_nxt = 1'b1;
        out_nxt   = pix1_q;
      end else begin
        s2_valid_nxt = 1'b0;
        phase_nxt    = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_y0    <= '0;
      s1_y1    <= '0;
      s1_tr    <= '0;
      s1_tg    <= '0;
      s1_tb    <= '0;
      s2_valid <= 1'b0;
      phase    <= 1'b0;
      out_q    <= '0;
      pix1_q   <= '0;
    end else begin
      s1_valid <= s1_valid_nxt;
      s1_y0    <= s1_y0_nxt;
      s1_y1    <= s1_y1_nxt;
      s1_tr    <= s1_tr_nxt;
      s1_tg    <= s1_tg_nxt;
      s1_tb    <= s1_tb_nxt;
      s2_valid <= s2_valid_nxt;
      phase    <= phase_nxt;
      out_q    <= out_nxt;
      pix1_q   <= pix1_nxt;
    end
  end

  assign o_valid = s2_valid;
  assign o_r     = out_q.r;
  assign o_g     = out_q.g;
  assign o_b     = out_q.b;

endmodule

// File: tb/tb_yuv422_to_rgb888.sv
// Scoreboard bench for yuv422_to_rgb888: accepted pairs push expected pixels,
// a negedge monitor pops and compares on every output transfer.
module tb_yuv422_to_rgb888;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_y0, i_y1, i_u, i_v;
  logic       o_valid;
  logic       o_ready;
  logic [7:0] o_r, o_g, o_b;

  yuv422_to_rgb888 dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_y0(i_y0), .i_y1(i_y1), .i_u(i_u), .i_v(i_v),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_r(o_r), .o_g(o_g), .o_b(o_b)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          in_count    = 0;
  bit          use_model   = 1'b0;
  bit          last_in_acc = 1'b0;
  logic [23:0] exp_q[$];

  function automatic int clip(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  // Reference: BT.601 full-range Q8 with floor shift and clamping.
  function automatic logic [23:0] ref_pix(input int y, input int u, input int v);
    int du, dv, tr, tg, tb;
    du = u - 128;
    dv = v - 128;
    tr = (359 * dv + 128) >>> 8;
    tg = (88 * du + 183 * dv + 128) >>> 8;
    tb = (454 * du + 128) >>> 8;
    return {8'(clip(y + tr)), 8'(clip(y - tg)), 8'(clip(y + tb))};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: record input acceptance, compare every output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      last_in_acc = i_valid && i_ready;
      if (last_in_acc) begin
        in_count++;
        if (use_model) begin
          exp_q.push_back(ref_pix(i_y0, i_u, i_v));
          exp_q.push_back(ref_pix(i_y1, i_u, i_v));
        end
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pixel: got %02h%02h%02h expected none at %0t",
                   o_r, o_g, o_b, $time);
        end else begin
          check("pixel", {o_r, o_g, o_b}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic new_pair();
    i_valid = 1'b1;
    i_y0 = 8'($urandom);
    i_y1 = 8'($urandom);
    i_u  = 8'($urandom);
    i_v  = 8'($urandom);
  endtask

  // One cycle: keep a pending pair until accepted, then maybe issue another.
  task automatic step(input int pv, input int pr);
    @(posedge clk);
    #1;
    if (!i_valid || last_in_acc) begin
      if (int'($urandom_range(99)) < pv) new_pair();
      else i_valid = 1'b0;
    end
    o_ready = (int'($urandom_range(99)) < pr);
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && (exp_q.size() != 0 || i_valid); c++) step(0, 100);
    check("drain_queue_empty", 24'(exp_q.size()), 24'd0);
  endtask

  task automatic send_fixed(input logic [7:0] y0, y1, u, v);
    @(posedge clk);
    #1;
    i_valid = 1'b1; i_y0 = y0; i_y1 = y1; i_u = u; i_v = v; o_ready = 1'b1;
  endtask

  // Fill S1+S2 with o_ready low, consume pixel 0, leaving phase 1 with S1 full.
  task automatic fill_to_phase1();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(100, 0);
      @(negedge clk);
      #1;
      seen = o_valid;
    end
    check("fill_o_valid", 24'(o_valid), 24'd1);
    step(100, 100);
    step(100, 0);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    i_y0 = '0; i_y1 = '0; i_u = '0; i_v = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_o_valid", 24'(o_valid), 24'd0);
    check("reset_rgb", {o_r, o_g, o_b}, 24'h000000);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_i_ready", 24'(i_ready), 24'd1);

    // Grey pair with latency check.
    use_model = 1'b0;
    exp_q.push_back(24'h808080);
    exp_q.push_back(24'h808080);
    send_fixed(8'd128, 8'd128, 8'd128, 8'd128);
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    #1 check("latency_early", 24'(o_valid), 24'd0);
    @(negedge clk);
    #1 check("latency_pix0", 24'(o_valid), 24'd1);
    drain();

    // Saturation at both ends.
    exp_q.push_back(24'hfe0000);
    exp_q.push_back(24'hffb3b3);
    send_fixed(8'd76, 8'd255, 8'd85, 8'd255);
    drain();

    // Streaming: 16 pairs, no bubbles, i_ready alternating.
    use_model = 1'b1;
    begin
      int   start;
      logic prev_rdy;
      start    = in_count;
      prev_rdy = 1'b0;
      for (int c = 0; c < 60 && in_count - start < 16; c++) begin
        step(100, 100);
        @(negedge clk);
        #1;
        if (c >= 2) begin
          check("stream_no_bubble", 24'(o_valid), 24'd1);
          check("stream_ready_alt", 24'(i_ready), 24'(!prev_rdy));
        end
        prev_rdy = i_ready;
      end
      check("stream_pairs", 24'(in_count - start), 24'd16);
      @(posedge clk);
      #1 i_valid = 1'b0;
      drain();
    end

    // Backpressure: o_ready low for 5 cycles after pixel 0.
    fill_to_phase1();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step(100, 0);
      @(negedge clk);
      #1;
      check("bp_hold_rgb", {o_r, o_g, o_b}, exp_q[0]);
      check("bp_o_valid", 24'(o_valid), 24'd1);
      check("bp_i_ready_low", 24'(i_ready), 24'd0);
    end
    drain();

    // Random valid/ready over 200 pairs.
    begin
      int start;
      start = in_count;
      for (int c = 0; c < 4000 && in_count - start < 200; c++) step(50, 50);
      check("random_pairs", 24'(in_count - start), 24'd200);
      drain();
    end

    // Reset in phase 1 with S1 full.
    fill_to_phase1();
    @(negedge clk);
    #2 rst = 1'b1;
    i_valid = 1'b0;
    #1;
    check("midrst_o_valid", 24'(o_valid), 24'd0);
    check("midrst_rgb", {o_r, o_g, o_b}, 24'h000000);
    exp_q.delete();
    last_in_acc = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("postrst_i_ready", 24'(i_ready), 24'd1);
    check("postrst_o_valid", 24'(o_valid), 24'd0);
    step(100, 100);
    @(posedge clk);
    #1 i_valid = 1'b0;
    drain();

    check("final_queue_empty", 24'(exp_q.size()), 24'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
